histogram_axi_reader: RTL and testbench
=======================================

Name: histogram_axi_reader

Overview:
AXI4-Lite read initiator that drains the frame histogram from the histogram AXI4-Lite read slave, one bin per transaction. On a start pulse it issues NUM_BINS sequential single reads and forwards each bin as a valid/ready stream to downstream logic (equalisation LUT builder, debug UART). It also accumulates the total pixel count and tracks the peak bin. It sits in the microblaze_clk domain, directly facing the slave's s_axi_ar*/s_axi_r* ports.

Parameters:
ADDR_BITS, 8, AXI read address width; address = bin index, one word per bin.
NUM_BINS, 256, number of bins read per sweep (1..2**ADDR_BITS).
BASE_ADDR, 0, address of bin 0.

Ports:
clk  in  1  clock; microblaze_clk domain.
rst  in  1  asynchronous reset, active-low.
start  in  1  single-cycle sweep request.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse after last bin handed off.
err  out  1  sticky: some RRESP != OKAY in current/last sweep.
m_axi_araddr  out  ADDR_BITS  read address.
m_axi_arvalid  out  1  address valid.
m_axi_arready  in  1  address accepted.
m_axi_rdata  in  32  bin count.
m_axi_rresp  in  2  read response.
m_axi_rvalid  in  1  read data valid.
m_axi_rready  out  1  read data accept.
bin_idx  out  8  index of bin on bin_data.
bin_data  out  32  bin count.
bin_valid  out  1  stream valid.
bin_ready  in  1  stream ready.
total  out  40  sum of all bins of last sweep.
peak_idx  out  8  index of largest bin.
peak_val  out  32  largest bin count.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 (arvalid, rready, bin_valid, busy, done, err, araddr, bin_idx, bin_data, total, peak_*). Reset mid-sweep aborts immediately; no resume.
- FSM: IDLE -> ADDR -> DATA -> OUT -> (ADDR | FIN) -> IDLE.
- IDLE: start=1 -> clear err, total, peak_val, peak_idx, index=0; busy=1; go ADDR next cycle. start while busy ignored.
- ADDR: arvalid=1, araddr = (BASE_ADDR+index) mod 2**ADDR_BITS, stable while arvalid. Leave on arvalid&&arready (same-cycle ready allowed, arvalid then drops next cycle) -> DATA.
- DATA: rready=1. Exactly one outstanding read; never assert arvalid in DATA. On rvalid&&rready: register bin_data=rdata, bin_idx=index; err |= (rresp!=2'b00); total += rdata (zero-extended, 40-bit, no overflow possible); if rdata > peak_val (strict) update peak_val/peak_idx, so ties keep lowest index; also first bin always loads peak (peak_val starts 0, index 0). -> OUT.
- OUT: bin_valid=1, bin_data/bin_idx stable until bin_ready. On bin_valid&&bin_ready: if index==NUM_BINS-1 -> FIN else index+1, -> ADDR.
- FIN: done=1 for one cycle, busy=0 -> IDLE. total/peak/err held until next start.
- Error responses do not abort; data still forwarded.
- Minimum per-bin cost with arready, rvalid, bin_ready tied high: 3 cycles (ADDR, DATA, OUT); full 256-bin sweep = 768 cycles + 1 (FIN) after the start cycle.
- No combinational path from any input to any output; all outputs registered.
- start coincident with done cycle ignored (busy still considered high).

Test Plan:
- Slave model returns rdata=index for all 256 bins, zero wait states -> 256 stream beats idx 0..255 in order, total=32640, peak_idx=255, peak_val=255, done one pulse 769 cycles after start, err=0.
- arready delayed 3 cycles, rvalid delayed 5 cycles per read -> araddr/arvalid stable while waiting, one outstanding read, same data as above, no dropped or duplicated bins.
- bin_ready low for 10 cycles on bin 7 -> bin_data/bin_idx=7 held, no AR issued until handshake, sweep continues afterwards.
- All bins 0 except bins 20 and 40 = 0xFFFFFFFF -> peak_idx=20, total=0x1FFFFFFFE.
- rresp=2'b10 on bin 100 only -> err=1 at end, all 256 bins still forwarded; next start clears err.
- rst pulled low during DATA of bin 50 -> all outputs 0 asynchronously; new start after release sweeps from bin 0.

Source files
------------

// File: rtl/histogram_axi_reader.sv
// AXI4-Lite read initiator: sweeps histogram bins one read at a time,
// streams each bin out and tracks running total and peak bin.
module histogram_axi_reader #(
  parameter int ADDR_BITS = 8,
  parameter int NUM_BINS  = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  output logic [7:0]           bin_idx,
  output logic [31:0]          bin_data,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [39:0]          total,
  output logic [7:0]           peak_idx,
  output logic [31:0]          peak_val
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OUT,
    S_FIN
  } state_t;

  localparam logic [ADDR_BITS-1:0] LP_BASE = ADDR_BITS'(BASE_ADDR);
  localparam logic [ADDR_BITS-1:0] LP_LAST = ADDR_BITS'(NUM_BINS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [ADDR_BITS-1:0]   r_araddr;
  logic [ADDR_BITS-1:0]   w_idx_nxt;
  logic [7:0]             r_bin_idx;
  logic [31:0]            r_bin_data;
  logic [39:0]            r_total;
  logic [7:0]             r_peak_idx;
  logic [31:0]            r_peak_val;
  logic                   r_err;
  logic                   w_start_ok;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_out_hs;
  logic                   w_last;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_ar_hs    = (r_state == S_ADDR) && m_axi_arready;
  assign w_r_hs     = (r_state == S_DATA) && m_axi_rvalid;
  assign w_out_hs   = (r_state == S_OUT) && bin_ready;
  assign w_last     = (r_idx == LP_LAST);
  assign w_idx_nxt  = r_idx + ADDR_BITS'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start)         w_next = S_ADDR;
      S_ADDR: if (m_axi_arready) w_next = S_DATA;
      S_DATA: if (m_axi_rvalid)  w_next = S_OUT;
      S_OUT:  if (bin_ready)     w_next = w_last ? S_FIN : S_ADDR;
      S_FIN:                     w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so no input reaches
  // an output combinationally.
  always_comb begin
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    bin_valid     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (r_state)
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        busy          = 1'b1;
      end
      S_DATA: begin
        m_axi_rready = 1'b1;
        busy         = 1'b1;
      end
      S_OUT: begin
        bin_valid = 1'b1;
        busy      = 1'b1;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_araddr   <= '0;
      r_bin_idx  <= '0;
      r_bin_data <= '0;
      r_total    <= '0;
      r_peak_idx <= '0;
      r_peak_val <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_idx      <= '0;
        r_araddr   <= LP_BASE;
        r_total    <= '0;
        r_peak_idx <= '0;
        r_peak_val <= '0;
        r_err      <= 1'b0;
      end
      if (w_r_hs) begin
        r_bin_data <= m_axi_rdata;
        r_bin_idx  <= 8'(r_idx);
        r_total    <= r_total + {8'd0, m_axi_rdata};
        if (m_axi_rresp != 2'b00) r_err <= 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (m_axi_rdata > r_peak_val) begin
          r_peak_val <= m_axi_rdata;
          r_peak_idx <= 8'(r_idx);
        end
      end
      if (w_out_hs && !w_last) begin
        r_idx    <= w_idx_nxt;
        r_araddr <= LP_BASE + w_idx_nxt;
      end
    end
  end

  assign m_axi_araddr = r_araddr;
  assign bin_idx      = r_bin_idx;
  assign bin_data     = r_bin_data;
  assign total        = r_total;
  assign peak_idx     = r_peak_idx;
  assign peak_val     = r_peak_val;
  assign err          = r_err;

endmodule

// File: tb/tb_histogram_axi_reader.sv
// Bench for histogram_axi_reader: AXI slave and stream sink model
// with a queue scoreboard of expected bins.
module tb_histogram_axi_reader;

  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [7:0]  bin_idx;
  logic [31:0] bin_data;
  logic        bin_valid;
  logic        bin_ready = 1'b1;
  logic [39:0] total;
  logic [7:0]  peak_idx;
  logic [31:0] peak_val;

  histogram_axi_reader #(
    .ADDR_BITS(8),
    .NUM_BINS (NB),
    .BASE_ADDR(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .m_axi_araddr (araddr),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .bin_idx      (bin_idx),
    .bin_data     (bin_data),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .total        (total),
    .peak_idx     (peak_idx),
    .peak_val     (peak_val)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NB];
  int          ar_dly = 0;
  int          r_dly = 0;
  int          bad_idx = -1;
  int          stall_idx = -1;
  int          stall_left = 0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  int          ar_exp = 0;
  bit          pend = 0;
  bit          ar_wait = 0;
  logic [7:0]  pend_addr = '0;
  logic [7:0]  ar_first = '0;
  logic [39:0] q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave and sink decide next-edge inputs on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      pend      = 0;
      ar_cnt    = 0;
      r_cnt     = 0;
      ar_wait   = 0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      bin_ready = 1'b1;
    end else begin
      rvalid = 1'b0;
      rresp  = 2'b00;
      rdata  = '0;
      if (pend) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1'b1;
          rdata  = mem[pend_addr];
          rresp  = (int'(pend_addr) == bad_idx) ? 2'b10 : 2'b00;
          if (rready) pend = 0;
        end else begin
          r_cnt++;
        end
      end
      arready = 1'b0;
      if (arvalid) begin
        if (!ar_wait) begin
          ar_wait  = 1;
          ar_first = araddr;
        end
        if (ar_cnt >= ar_dly) begin
          arready = 1'b1;
          chk("ar_one_outstanding", 64'(pend), 64'd0);
          chk("ar_addr", 64'(araddr), 64'(ar_exp[7:0]));
          chk("ar_stable", 64'(araddr), 64'(ar_first));
          pend      = 1;
          pend_addr = araddr;
          r_cnt     = 0;
          ar_cnt    = 0;
          ar_wait   = 0;
          ar_exp++;
        end else begin
          ar_cnt++;
        end
      end
      bin_ready = 1'b1;
      if (bin_valid) begin
        if (int'(bin_idx) == stall_idx && stall_left > 0) begin
          bin_ready = 1'b0;
          stall_left--;
          chk("stall_hold", 64'({bin_idx, bin_data}), 64'(q[0]));
          chk("stall_no_ar", 64'(arvalid), 64'd0);
        end else begin
          logic [63:0] e;
          e = 'x;
          if (q.size() > 0) e = 64'(q.pop_front());
          chk("beat", 64'({bin_idx, bin_data}), e);
        end
      end
    end
  end

  task automatic sweep(input string tag, input int exp_cyc);
    logic [39:0] tot;
    logic [31:0] pv;
    int          pi;
    bit          e;
    int          cyc;
    tot = '0;
    pv  = '0;
    pi  = 0;
    e   = 0;
    cyc = 0;
    for (int i = 0; i < NB; i++) begin
      q.push_back({8'(i), mem[i]});
      tot += {8'd0, mem[i]};
      if (mem[i] > pv) begin
        pv = mem[i];
        pi = i;
      end
      if (i == bad_idx) e = 1;
    end
    ar_exp = 0;
    @(negedge clk);
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 2) chk({tag, "_err_cleared"}, 64'(err), 64'd0);
    end while (!done && cyc < 6000);
    chk({tag, "_done"}, 64'(done), 64'd1);
    if (exp_cyc > 0) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_total"}, 64'(total), 64'(tot));
    chk({tag, "_peak_idx"}, 64'(peak_idx), 64'(pi));
    chk({tag, "_peak_val"}, 64'(peak_val), 64'(pv));
    chk({tag, "_err"}, 64'(err), 64'(e));
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    q.delete();
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int w;
    #12;
    chk("rst_ctrl", 64'({busy, done, err, arvalid, rready, bin_valid}), 64'd0);
    chk("rst_bus", 64'({araddr, bin_idx, bin_data}), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    chk("rst_peak", 64'({peak_idx, peak_val}), 64'd0);
    #10;
    rst = 1'b1;

    for (int i = 0; i < NB; i++) mem[i] = 32'(i);
    sweep("ramp", 769);

    ar_dly = 3;
    r_dly  = 5;
    sweep("slow", 2817);
    ar_dly = 0;
    r_dly  = 0;

    stall_idx  = 7;
    stall_left = 10;
    sweep("stall", 779);
    stall_idx = -1;

    for (int i = 0; i < NB; i++) mem[i] = '0;
    mem[20] = 32'hFFFF_FFFF;
    mem[40] = 32'hFFFF_FFFF;
    sweep("tie", 769);
    chk("tie_total_const", 64'(total), 64'h1_FFFF_FFFE);

    for (int i = 0; i < NB; i++) mem[i] = 32'(i * 3 + 1);
    bad_idx = 100;
    sweep("bad", 769);
    bad_idx = -1;
    sweep("clean", 769);

    for (int i = 0; i < NB; i++) mem[i] = 32'(i);
    r_dly = 5;
    for (int i = 0; i < 50; i++) q.push_back({8'(i), mem[i]});
    ar_exp = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(ar_exp == 51 && rready) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reached", 64'(rready), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_ctrl", 64'({busy, done, err, arvalid, rready, bin_valid}),
        64'd0);
    chk("abort_bus", 64'({araddr, bin_idx, bin_data}), 64'd0);
    chk("abort_total", 64'(total), 64'd0);
    chk("abort_peak", 64'({peak_idx, peak_val}), 64'd0);
    chk("abort_queue", 64'(q.size()), 64'd0);
    q.delete();
    r_dly = 0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    sweep("after_rst", 769);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
